pixel_ring_scheduler: RTL
=========================

PIXEL_RING_SCHEDULER -- requirements
Module: pixel_ring_scheduler

Interface
REQ-001 Parameter RING_DEPTH, default 1024: ring buffer length in words; one full revolution equals RING_DEPTH cycles.
REQ-002 Parameter DECAY_PERIOD, default 4096: cycles between starts of successive decay sweeps; SHALL be at least RING_DEPTH.
REQ-003 Parameter DECAY_STEP, default 12'd64: luma decrement applied once per word per sweep.
REQ-004 Parameter STARVE_LIMIT, default 64: cycles a pending pixel waits before a forced overwrite.
REQ-005 clock  in  1  single clock for all logic, rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 pix_valid  in  1  new pixel offered by the display source.
REQ-008 pix_data  in  32  new pixel {Y[31:22], X[21:12], luma[11:0]}.
REQ-009 pix_ready  out  1  pixel accepted this cycle when pix_valid and pix_ready are both high.
REQ-010 flush  in  1  single-cycle request to blank the whole ring.
REQ-011 ring_shiftout  in  32  oldest word returned by the ring buffer.
REQ-012 ring_shiftin  out  32  registered word written into the ring each cycle.
REQ-013 busy  out  1  high while the ring is being cleared.
REQ-014 decay_active  out  1  high during a decay sweep.
REQ-015 drop_count  out  16  count of still-lit words overwritten by forced insertions.

Function
REQ-016 The FSM SHALL have two states, CLEAR and RUN; reset_n low SHALL force CLEAR with the clear counter at 0.
REQ-017 In CLEAR, ring_shiftin SHALL be 0 every cycle for exactly RING_DEPTH cycles, after which the FSM SHALL enter RUN; busy SHALL be 1 and pix_ready 0 throughout CLEAR.
REQ-018 A flush seen in RUN SHALL enter CLEAR on the next cycle with the clear counter at 0; a flush seen in CLEAR SHALL restart the clear counter at 0.
REQ-019 Recirculated word r' SHALL be ring_shiftout; when decay_active is set, r' luma SHALL be max(luma - DECAY_STEP, 0), saturating at 0 with no wrap.
REQ-020 Any r' whose luma is 0 SHALL be replaced by the all-zero word, and its slot SHALL be treated as free.
REQ-021 pix_ready SHALL be combinational: RUN and (slot free or starve_cnt equal to STARVE_LIMIT).
REQ-022 On a transfer, the next ring_shiftin SHALL be pix_data unmodified; otherwise, in RUN, it SHALL be r', giving one cycle of latency from ring_shiftout to ring_shiftin.
REQ-023 A transfer into a non-free slot is a forced overwrite: drop_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-024 starve_cnt SHALL increment each cycle with pix_valid high and pix_ready low, saturating at STARVE_LIMIT; it SHALL clear on a transfer, when pix_valid is low, and in CLEAR.
REQ-025 Decay counter dcnt SHALL count 0 to DECAY_PERIOD-1 in RUN and wrap to 0; it SHALL be held at 0 in CLEAR.
REQ-026 decay_active SHALL be RUN and (dcnt < RING_DEPTH), so every ring word is decayed exactly once per sweep.
REQ-027 A new pixel inserted while decay_active is high SHALL NOT be decayed on insertion.
REQ-028 pix_data with luma 0 SHALL still be accepted and written; the slot is then free again on its next pass.

Reset
REQ-029 After a reset_n low cycle, outputs SHALL be: ring_shiftin=0, busy=1, pix_ready=0, decay_active=0, drop_count=0; starve_cnt and dcnt SHALL be 0.
REQ-030 A reset asserted mid-clear or mid-sweep SHALL abort it and restart CLEAR from counter 0.
REQ-031 flush SHALL NOT clear drop_count; only reset_n SHALL clear it.

Verification
REQ-032 Bench: reset, ring_shiftout=0 -> busy high exactly 1024 cycles, ring_shiftin 0 throughout, then pix_ready=1.
REQ-033 Bench: in RUN, ring_shiftout luma 0, pix_valid with 0x12345FFF -> ring_shiftin=0x12345FFF next cycle, drop_count unchanged.
REQ-034 Bench: ring_shiftout luma 0x800 constant, pix_valid held -> pix_ready low 64 cycles, high on cycle 65, drop_count=1.
REQ-035 Bench: ring_shiftout luma 0x030 with decay_active high -> ring_shiftin=0 (saturated, word zeroed); luma 0x100 -> 0x0C0.
REQ-036 Bench: flush pulse mid-sweep -> decay_active drops next cycle, busy high 1024 cycles, drop_count retained.
REQ-037 Bench: decay_active measured over 8192 RUN cycles -> high exactly 2048 cycles, in two 1024-cycle windows starting 4096 apart.

Source files
------------

// File: rtl/pixel_ring_scheduler.sv
// Pixel ring scheduler: it clears the external ring, recirculates and decays its words,
// and inserts new pixels into free slots (or forces them in after starvation).
module pixel_ring_scheduler #(
  parameter int          RING_DEPTH   = 1024,
  parameter int          DECAY_PERIOD = 4096,
  parameter logic [11:0] DECAY_STEP   = 12'd64,
  parameter int          STARVE_LIMIT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pix_valid,
  input  logic [31:0] pix_data,
  output logic        pix_ready,
  input  logic        flush,
  input  logic [31:0] ring_shiftout,
  output logic [31:0] ring_shiftin,
  output logic        busy,
  output logic        decay_active,
  output logic [15:0] drop_count,
  output logic        o_dbg_state
);

  localparam int CW = $clog2(RING_DEPTH + 1);
  localparam int DW = $clog2(DECAY_PERIOD + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(RING_DEPTH - 1);
  localparam logic [DW-1:0] DCNT_LAST  = DW'(DECAY_PERIOD - 1);
  localparam logic [DW-1:0] SWEEP_LEN  = DW'(RING_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_clr_cnt;
  logic [DW-1:0] r_dcnt;
  logic [SW-1:0] r_starve;
  logic [15:0]   r_drop;
  logic [31:0]   r_shiftin;

  logic          w_run;
  logic [11:0]   w_luma_in;
  logic [11:0]   w_luma_dec;
  logic          w_free;
  logic [31:0]   w_recirc;
  logic          w_ready;
  logic          w_xfer;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (!flush && r_clr_cnt == CLR_LAST) w_state_nxt = S_RUN;
      S_RUN:   if (flush) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Decay saturates at zero; a zero-luma word is blanked and its slot counts as free.
  assign w_run        = (r_state == S_RUN);
  assign decay_active = w_run && (r_dcnt < SWEEP_LEN);
  assign w_luma_in    = ring_shiftout[11:0];
  assign w_luma_dec   = !decay_active ? w_luma_in :
                        (w_luma_in > DECAY_STEP) ? (w_luma_in - DECAY_STEP) : 12'd0;
  assign w_free       = (w_luma_dec == 12'd0);
  assign w_recirc     = w_free ? 32'd0 : {ring_shiftout[31:12], w_luma_dec};
  assign w_ready      = w_run && (w_free || r_starve == STARVE_MAX);
  assign w_xfer       = pix_valid && w_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_dcnt    <= '0;
      r_starve  <= '0;
      r_drop    <= '0;
      r_shiftin <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_CLEAR && !flush) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                              r_clr_cnt <= '0;

      if (r_state == S_RUN && w_state_nxt == S_RUN)
        r_dcnt <= (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + 1'b1;
      else
        r_dcnt <= '0;

      // Starvation only accumulates while a valid pixel is being refused in RUN.
      if (r_state != S_RUN || w_state_nxt != S_RUN || w_xfer || !pix_valid)
        r_starve <= '0;
      else if (r_starve != STARVE_MAX)
        r_starve <= r_starve + 1'b1;

      if (w_xfer && !w_free && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;

      if (r_state != S_RUN) r_shiftin <= '0;
      else if (w_xfer)      r_shiftin <= pix_data;
      else                  r_shiftin <= w_recirc;
    end
  end

  assign busy         = (r_state == S_CLEAR);
  assign pix_ready    = w_ready;
  assign ring_shiftin = r_shiftin;
  assign drop_count   = r_drop;
  assign o_dbg_state  = r_state;

endmodule
